// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle between the configuration side and clk_div_ctrl.
// The master side issues run requests and ratio updates; the slave side is the controller.
interface clk_div_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;
  logic             clk_div;
  logic             tick;
  logic             active;
  logic             err;

  modport master (
    output en, cfg_valid, cfg_div,
    input  cfg_ready, clk_div, tick, active, err
  );

  modport slave (
    input  en, cfg_valid, cfg_div,
    output cfg_ready, clk_div, tick, active, err
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time clock-divider controller: owns the divide ratio and starts, stops and
// re-ratios the divided clock only on period boundaries (the falling toggle).
module clk_div_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input logic           clk,
  input logic           reset,
  clk_div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_STOP     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

  state_e           state_q;
  logic [WIDTH-1:0] cur_div_q;
  logic [WIDTH-1:0] pend_div_q;
  logic [WIDTH-1:0] counter_q;
  logic             pend_valid_q;
  logic             clk_div_q;
  logic             tick_q;
  logic             err_q;
  logic             active_q;

  logic             xfer_s;
  logic             cfg_ok_s;
  logic             toggle_s;
  logic             fall_s;

  assign bus.cfg_ready = !pend_valid_q;
  assign bus.clk_div   = clk_div_q;
  assign bus.tick      = tick_q;
  assign bus.active    = active_q;
  assign bus.err       = err_q;

  // Handshake and period-position decode.
  always_comb begin
    xfer_s   = bus.cfg_valid && !pend_valid_q;
    cfg_ok_s = xfer_s && (bus.cfg_div != ZERO);
    toggle_s = (counter_q == cur_div_q);
    fall_s   = toggle_s && clk_div_q;
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_STOP;
      cur_div_q    <= DIV_RST;
      pend_div_q   <= DIV_RST;
      pend_valid_q <= 1'b0;
      counter_q    <= ONE;
      clk_div_q    <= 1'b0;
      tick_q       <= 1'b0;
      err_q        <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      err_q  <= xfer_s && !cfg_ok_s;
      tick_q <= 1'b0;
      case (state_q)
        ST_STOP: begin
          if (cfg_ok_s) begin
            cur_div_q <= bus.cfg_div;
          end
          if (bus.en) begin
            state_q   <= ST_RUN;
            active_q  <= 1'b1;
            counter_q <= ONE;
          end
        end
        ST_RUN, ST_STOPPING: begin
          if ((state_q == ST_RUN) && !bus.en && !clk_div_q) begin
            // Output already idle-low: stop at once, folding in any ratio update.
            state_q      <= ST_STOP;
            active_q     <= 1'b0;
            counter_q    <= ONE;
            pend_valid_q <= 1'b0;
            if (cfg_ok_s) begin
              cur_div_q <= bus.cfg_div;
            end else if (pend_valid_q) begin
              cur_div_q <= pend_div_q;
            end
          end else begin
            if (toggle_s) begin
              counter_q <= ONE;
              clk_div_q <= ~clk_div_q;
              tick_q    <= 1'b1;
            end else begin
              counter_q <= counter_q + ONE;
            end
            if (fall_s && !bus.en) begin
              state_q      <= ST_STOP;
              active_q     <= 1'b0;
              pend_valid_q <= 1'b0;
              if (cfg_ok_s) begin
                cur_div_q <= bus.cfg_div;
              end else if (pend_valid_q) begin
                cur_div_q <= pend_div_q;
              end
            end else begin
              // A ratio accepted on this falling edge waits for the next one.
              if (fall_s && pend_valid_q) begin
                cur_div_q    <= pend_div_q;
                pend_valid_q <= 1'b0;
              end
              if (cfg_ok_s) begin
                pend_div_q   <= bus.cfg_div;
                pend_valid_q <= 1'b1;
              end
              state_q <= bus.en ? ST_RUN : ST_STOPPING;
            end
          end
        end
        default: begin
          state_q      <= ST_STOP;
          active_q     <= 1'b0;
          counter_q    <= ONE;
          clk_div_q    <= 1'b0;
          pend_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
